// File: rtl/gen_reg_pkg.sv
// Shared types and helpers for the gen_reg_array register file and its serial nibble loader.
package gen_reg_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } ser_state_t;

    // Number of nibble lanes in a register of the given width.
    function automatic int lane_count(input int data_w);
        return data_w / NIB_W;
    endfunction

endpackage

// File: rtl/gen_reg_array_nibble_assembler.sv
// Serial nibble loader: collects LANES nibbles LSB-first into a word, then emits one commit cycle.
module nibble_assembler
    import gen_reg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    localparam int LANES = lane_count(DATA_W),
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ser_start,
    input  logic [ADDR_W-1:0] ser_addr,
    input  logic              ser_valid,
    input  logic [NIB_W-1:0]  ser_nib,
    output logic              ser_ready,
    output logic              ser_done,
    output logic              busy,
    output logic              commit,
    output logic [ADDR_W-1:0] commit_addr,
    output logic [DATA_W-1:0] commit_data
);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    ser_state_t        state;
    ser_state_t        next_state;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] buffer;
    logic [ADDR_W-1:0] target;
    logic              accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ser_ready  = 1'b0;
        busy       = 1'b0;
        commit     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (ser_start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                ser_ready = 1'b1;
                busy      = 1'b1;
                accept    = ser_valid;
                if (ser_valid && count == LAST_LANE) begin
                    next_state = COMMIT;
                end
            end
            COMMIT: begin
                busy       = 1'b1;
                commit     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The buffer is complete on entry to COMMIT because the last nibble lands on that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            buffer <= '0;
            target <= '0;
        end else if (state == IDLE && ser_start) begin
            target <= ser_addr;
            count  <= '0;
        end else if (accept) begin
            buffer[count*NIB_W +: NIB_W] <= ser_nib;
            count                        <= count + 1'b1;
        end
    end

    assign ser_done    = commit;
    assign commit_addr = target;
    assign commit_data = buffer;

endmodule

// File: rtl/gen_reg_array.sv
// Register array with two combinational read ports, lane-masked parallel writes and a serial loader.
// Define GEN_REG_BYPASS_EN to let reads see the value being written in the same cycle.
module gen_reg_array
    import gen_reg_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    localparam int LANES   = lane_count(DATA_W),
    localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LANES-1:0]  wr_lane,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ser_start,
    input  logic [ADDR_W-1:0] ser_addr,
    input  logic              ser_valid,
    input  logic [NIB_W-1:0]  ser_nib,
    output logic              ser_ready,
    output logic              ser_done,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy
);

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic              commit;
    logic [ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0] commit_data;

    logic [DATA_W-1:0] regs      [NUM_REGS];
    logic [DATA_W-1:0] next_regs [NUM_REGS];
    logic [DATA_W-1:0] view      [NUM_REGS];

    nibble_assembler #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_assembler (
        .clk         (clk),
        .reset       (reset),
        .ser_start   (ser_start),
        .ser_addr    (ser_addr),
        .ser_valid   (ser_valid),
        .ser_nib     (ser_nib),
        .ser_ready   (ser_ready),
        .ser_done    (ser_done),
        .busy        (busy),
        .commit      (commit),
        .commit_addr (commit_addr),
        .commit_data (commit_data)
    );

    // A commit replaces the whole word, so it silently wins over a parallel write to the same register.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            next_regs[r] = regs[r];
            if (wr_en && wr_addr == ADDR_W'(r)) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wr_lane[l]) begin
                        next_regs[r][l*NIB_W +: NIB_W] = wr_data[l*NIB_W +: NIB_W];
                    end
                end
            end
            if (commit && commit_addr == ADDR_W'(r)) begin
                next_regs[r] = commit_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= next_regs[r];
            end
        end
    end

`ifdef GEN_REG_BYPASS_EN
    assign view = next_regs;
`else
    assign view = regs;
`endif

    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if ({1'b0, rd_addr_a} < REG_LIMIT) begin
            rd_data_a = view[rd_addr_a];
        end
        if ({1'b0, rd_addr_b} < REG_LIMIT) begin
            rd_data_b = view[rd_addr_b];
        end
    end

endmodule

// File: tb/tb_gen_reg_array.sv
// Scoreboard bench for gen_reg_array (DATA_W=16, NUM_REGS=4) with a queue-based reference model.
// Build with GEN_REG_BYPASS_EN defined to expect same-cycle read bypass.
module tb_gen_reg_array;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 4;
    localparam int LANES    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [3:0]  wr_lane;
    logic [15:0] wr_data;
    logic        ser_start;
    logic [1:0]  ser_addr;
    logic        ser_valid;
    logic [3:0]  ser_nib;
    logic        ser_ready;
    logic        ser_done;
    logic [1:0]  rd_addr_a;
    logic [1:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        busy;

    gen_reg_array #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_lane   (wr_lane),
        .wr_data   (wr_data),
        .ser_start (ser_start),
        .ser_addr  (ser_addr),
        .ser_valid (ser_valid),
        .ser_nib   (ser_nib),
        .ser_ready (ser_ready),
        .ser_done  (ser_done),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] rd_a;
        logic [15:0] rd_b;
        logic        busy;
        logic        ready;
        logic        done;
    } chk_t;

    chk_t chk_q[$];
    chk_t mon_c;
    logic chk_req = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: register contents plus the in-flight serial load as a list of nibbles.
    logic [15:0] mregs [NUM_REGS];
    logic [15:0] nxt   [NUM_REGS];
    bit          loading;
    bit          committing;
    int          target;
    logic [3:0]  nibs[$];

    function automatic void model_reset();
        for (int r = 0; r < NUM_REGS; r++) mregs[r] = '0;
        loading    = 1'b0;
        committing = 1'b0;
        target     = 0;
        nibs.delete();
    endfunction

    function automatic logic [15:0] assembled();
        logic [15:0] w;
        w = '0;
        foreach (nibs[i]) w = w | (16'(nibs[i]) << (4 * i));
        return w;
    endfunction

    function automatic void calc_next();
        logic [15:0] mask;
        for (int r = 0; r < NUM_REGS; r++) nxt[r] = mregs[r];
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_lane[l]) begin
                    mask = 16'hF << (4 * l);
                    nxt[wr_addr] = (nxt[wr_addr] & ~mask) | (wr_data & mask);
                end
            end
        end
        if (committing && target < NUM_REGS) nxt[target] = assembled();
    endfunction

    function automatic void model_edge();
        for (int r = 0; r < NUM_REGS; r++) mregs[r] = nxt[r];
        if (committing) begin
            committing = 1'b0;
        end else if (loading) begin
            if (ser_valid) begin
                nibs.push_back(ser_nib);
                if (nibs.size() == LANES) begin
                    loading    = 1'b0;
                    committing = 1'b1;
                end
            end
        end else if (ser_start) begin
            loading = 1'b1;
            target  = int'(ser_addr);
            nibs.delete();
        end
    endfunction

    function automatic logic [15:0] model_read(input logic [1:0] a);
`ifdef GEN_REG_BYPASS_EN
        return nxt[a];
`else
        return mregs[a];
`endif
    endfunction

    function automatic void cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %h, required %h", name, act, exp);
        end
    endfunction

    task automatic applyStimulus(input logic we, input logic [1:0] wa, input logic [3:0] wl,
                                 input logic [15:0] wd, input logic ss, input logic [1:0] sa,
                                 input logic sv, input logic [3:0] sn,
                                 input logic [1:0] ra, input logic [1:0] rb);
        wr_en     = we;
        wr_addr   = wa;
        wr_lane   = wl;
        wr_data   = wd;
        ser_start = ss;
        ser_addr  = sa;
        ser_valid = sv;
        ser_nib   = sn;
        rd_addr_a = ra;
        rd_addr_b = rb;
    endtask

    // Queue the expected response for the inputs now applied, then advance one clock.
    task automatic checkOutput(input string name);
        chk_t e;
        if (reset) model_reset();
        calc_next();
        e.name  = name;
        e.rd_a  = model_read(rd_addr_a);
        e.rd_b  = model_read(rd_addr_b);
        e.busy  = loading || committing;
        e.ready = loading;
        e.done  = committing && !reset;
        chk_q.push_back(e);
        chk_req = 1'b1;
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic idle(input logic [1:0] ra, input logic [1:0] rb, input string name);
        applyStimulus(1'b0, 2'd0, 4'h0, 16'h0, 1'b0, 2'd0, 1'b0, 4'h0, ra, rb);
        checkOutput(name);
    endtask

    task automatic serNib(input logic [3:0] n, input logic [1:0] ra, input string name);
        applyStimulus(1'b0, 2'd0, 4'h0, 16'h0, 1'b0, 2'd0, 1'b1, n, ra, ra);
        checkOutput(name);
    endtask

    // Monitor: compare every presented cycle against the oldest queued expectation.
    always @(negedge clk) begin
        if (chk_req) begin
            if (chk_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL scoreboard_empty: actual no entry, required one entry");
            end else begin
                mon_c = chk_q.pop_front();
                cmp({mon_c.name, "/rd_a"}, rd_data_a, mon_c.rd_a);
                cmp({mon_c.name, "/rd_b"}, rd_data_b, mon_c.rd_b);
                cmp({mon_c.name, "/busy"}, 16'(busy), 16'(mon_c.busy));
                cmp({mon_c.name, "/ready"}, 16'(ser_ready), 16'(mon_c.ready));
                cmp({mon_c.name, "/done"}, 16'(ser_done), 16'(mon_c.done));
            end
        end
    end

    initial begin
        #100000;
        n_checks++;
        n_fail++;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, 4'h0, 16'h0, 1'b0, 2'd0, 1'b0, 4'h0, 2'd0, 2'd1);
        model_reset();
        @(posedge clk);
        #1;
        idle(2'd0, 2'd1, "reset_r01");
        idle(2'd2, 2'd3, "reset_r23");
        reset = 1'b0;

        applyStimulus(1'b1, 2'd1, 4'b0011, 16'hABCD, 1'b0, 2'd0, 1'b0, 4'h0, 2'd1, 2'd0);
        checkOutput("par_lo_wr");
        applyStimulus(1'b1, 2'd1, 4'b1100, 16'h1234, 1'b0, 2'd0, 1'b0, 4'h0, 2'd1, 2'd0);
        checkOutput("par_hi_wr");
        applyStimulus(1'b1, 2'd1, 4'b0000, 16'hFFFF, 1'b0, 2'd0, 1'b0, 4'h0, 2'd1, 2'd0);
        checkOutput("par_nolane");
        idle(2'd1, 2'd0, "par_result");

        applyStimulus(1'b0, 2'd0, 4'h0, 16'h0, 1'b1, 2'd2, 1'b0, 4'h0, 2'd2, 2'd3);
        checkOutput("ser2_start");
        applyStimulus(1'b0, 2'd0, 4'h0, 16'h0, 1'b1, 2'd3, 1'b1, 4'h4, 2'd2, 2'd3);
        checkOutput("ser2_nib0_busy_start");
        serNib(4'h3, 2'd2, "ser2_nib1");
        idle(2'd2, 2'd3, "ser2_gap");
        serNib(4'h2, 2'd2, "ser2_nib2");
        serNib(4'h1, 2'd2, "ser2_nib3");
        idle(2'd2, 2'd3, "ser2_commit");
        idle(2'd2, 2'd3, "ser2_result");

        applyStimulus(1'b0, 2'd0, 4'h0, 16'h0, 1'b1, 2'd3, 1'b0, 4'h0, 2'd3, 2'd0);
        checkOutput("ser3_start");
        serNib(4'hA, 2'd3, "ser3_nib");
        serNib(4'h5, 2'd3, "ser3_nib");
        serNib(4'hC, 2'd3, "ser3_nib");
        serNib(4'h3, 2'd3, "ser3_nib");
        applyStimulus(1'b1, 2'd3, 4'hF, 16'hFFFF, 1'b0, 2'd0, 1'b0, 4'h0, 2'd3, 2'd0);
        checkOutput("ser3_commit_same_reg");
        idle(2'd3, 2'd0, "ser3_result");

        applyStimulus(1'b0, 2'd0, 4'h0, 16'h0, 1'b1, 2'd3, 1'b0, 4'h0, 2'd3, 2'd0);
        checkOutput("ser3b_start");
        serNib(4'h1, 2'd3, "ser3b_nib");
        serNib(4'hE, 2'd3, "ser3b_nib");
        serNib(4'h2, 2'd3, "ser3b_nib");
        serNib(4'hD, 2'd3, "ser3b_nib");
        applyStimulus(1'b1, 2'd0, 4'hF, 16'hFFFF, 1'b0, 2'd0, 1'b0, 4'h0, 2'd3, 2'd0);
        checkOutput("ser3b_commit_other_reg");
        idle(2'd3, 2'd0, "ser3b_result");

        applyStimulus(1'b0, 2'd0, 4'h0, 16'h0, 1'b1, 2'd2, 1'b0, 4'h0, 2'd2, 2'd0);
        checkOutput("abort_start");
        serNib(4'h9, 2'd2, "abort_nib");
        serNib(4'h9, 2'd2, "abort_nib");
        reset = 1'b1;
        idle(2'd2, 2'd0, "abort_in_reset");
        reset = 1'b0;
        applyStimulus(1'b0, 2'd0, 4'h0, 16'h0, 1'b1, 2'd2, 1'b0, 4'h0, 2'd2, 2'd1);
        checkOutput("reload_start");
        serNib(4'h8, 2'd2, "reload_nib");
        serNib(4'h7, 2'd2, "reload_nib");
        serNib(4'h6, 2'd2, "reload_nib");
        serNib(4'h5, 2'd2, "reload_nib");
        idle(2'd2, 2'd1, "reload_commit");
        idle(2'd2, 2'd1, "reload_result");

        applyStimulus(1'b1, 2'd0, 4'hF, 16'h5555, 1'b0, 2'd0, 1'b0, 4'h0, 2'd0, 2'd2);
        checkOutput("bypass_same_cycle");
        idle(2'd0, 2'd2, "bypass_next_cycle");

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom),
                          ($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom),
                          4'($urandom), 2'($urandom), 2'($urandom));
            checkOutput("random");
        end

        chk_req = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (chk_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: actual %0d pending, required 0", chk_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
